ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider beside the execute stage. Serves DIV and DIVU.
- Execute issues operands and a start pulse, and holds the pipeline while busy=1.
- On completion the block presents quotient and remainder. Execute forwards them as lo_o and hi_o with we_hilo=1, toward MEM/WB and the HI/LO register.

---
 rtl/ex_div_pkg.sv | 24 ++
 rtl/ex_div_step.sv | 23 ++
 rtl/ex_div.sv | 142 ++++++++++++++
 tb/tb_ex_div.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared constants and state encoding for the execute-stage divider
package ex_div_pkg;

    // ALU operation codes that route an instruction to the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Number of restoring iterations for a full-width divide
    localparam int DIV_ITER = 32;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Two's-complement magnitude when the operand is signed and negative
    function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// rtl/ex_div_step.sv - one combinational restoring-division iteration
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial,
    input  logic [WIDTH-1:0] divisor_mag,
    input  logic             bit_in,
    output logic [WIDTH-1:0] next_partial,
    output logic             quotient_bit
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {partial, bit_in};
    assign diff    = shifted - {1'b0, divisor_mag};

    // A clear top bit means no borrow: the trial subtraction is kept
    assign quotient_bit = ~diff[WIDTH];
    assign next_partial = quotient_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (optional EX_DIV_EARLY_OUT_EN)
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] orig_a;
    logic             neg_q;
    logic             neg_r;
    logic             early;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_z;
    logic [WIDTH-1:0] held_q;
    logic [WIDTH-1:0] held_r;
    logic             held_z;

    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fin;

    assign mag_a_in = signed_div && dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign mag_b_in = signed_div && divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // dq shifts dividend bits out of the top while quotient bits enter the bottom
    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .partial      (rem),
        .divisor_mag  (mag_b),
        .bit_in       (dq[WIDTH-1]),
        .next_partial (step_rem),
        .quotient_bit (step_q)
    );

    assign q_fin = {dq[WIDTH-2:0], step_q};

    // Result is only visible in DONE when not flushed; otherwise the last result is held
    assign busy        = (state != DIV_IDLE);
    assign ready       = (state == DIV_DONE) && !annul;
    assign quotient    = ready ? res_q : held_q;
    assign remainder   = ready ? res_r : held_r;
    assign div_by_zero = ready ? res_z : held_z;

    // Divider sequencer: operand capture, iteration, sign fix and result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            dq     <= '0;
            mag_b  <= '0;
            orig_a <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            early  <= 1'b0;
            res_q  <= '0;
            res_r  <= '0;
            res_z  <= 1'b0;
            held_q <= '0;
            held_r <= '0;
            held_z <= 1'b0;
        end else if (state != DIV_IDLE && annul) begin
            // Pipeline flush abandons the operation and keeps the previous result
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        cnt    <= '0;
                        rem    <= '0;
                        dq     <= mag_a_in;
                        mag_b  <= mag_b_in;
                        orig_a <= dividend;
                        neg_q  <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r  <= signed_div & dividend[WIDTH-1];
                        if (divisor == '0) begin
                            early <= 1'b0;
                            state <= DIV_ZERO;
                        end
`ifdef EX_DIV_EARLY_OUT_EN
                        else if (mag_a_in < mag_b_in) begin
                            // Quotient is trivially zero; reuse the one-cycle ZERO slot
                            early <= 1'b1;
                            state <= DIV_ZERO;
                        end
`endif
                        else begin
                            early <= 1'b0;
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_ZERO: begin
                    res_q <= early ? '0 : '1;
                    res_r <= orig_a;
                    res_z <= ~early;
                    state <= DIV_DONE;
                end
                DIV_RUN: begin
                    rem <= step_rem;
                    dq  <= q_fin;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        res_q <= neg_q ? (~q_fin + 1'b1) : q_fin;
                        res_r <= neg_r ? (~step_rem + 1'b1) : step_rem;
                        res_z <= 1'b0;
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    held_q <= res_q;
                    held_r <= res_r;
                    held_z <= res_z;
                    state  <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div with directed vectors
module tb_ex_div;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    ex_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .annul       (annul),
        .signed_div  (signed_div),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .ready       (ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready at cycle %0d q=%h r=%h", cyc, quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_q"}, quotient, e.q);
                chk({e.tag, "_r"}, remainder, e.r);
                chk({e.tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.z});
                chk({e.tag, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b, output int e0);
        @(negedge clk);
        start = 1'b1;
        signed_div = sg;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
    endtask

    task automatic expect_op(input string tag, input logic sg, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                             input logic z, input int lat);
        int   e0;
        exp_t e;
        issue(sg, a, b, e0);
        e.q = q; e.r = r; e.z = z; e.due = e0 + lat - 1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout pending %0d expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int e0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // DIVU 100/7 with busy window checks
        expect_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clk);
        chk("busy_c1", {31'd0, busy}, 32'd1);
        repeat (32) @(negedge clk);
        chk("busy_c33", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_c34", {31'd0, busy}, 32'd0);
        drain("divu_100_7");

        expect_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        drain("div_m7_2");
        expect_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        drain("div_7_m2");
        expect_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        drain("div_min_m1");
        expect_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        drain("divu_max_1");
        expect_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
        drain("divu_5_0");

        // start together with annul in IDLE is ignored
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        chk("start_annul_busy", {31'd0, busy}, 32'd0);

        // Annul mid-run: no ready, previous result held
        issue(1'b0, 32'd10, 32'd3, e0);
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy_c11", {31'd0, busy}, 32'd0);
        chk("annul_hold_q", quotient, 32'hFFFF_FFFF);
        chk("annul_hold_r", remainder, 32'd5);
        chk("annul_hold_dbz", {31'd0, div_by_zero}, 32'd1);
        repeat (40) @(negedge clk);
        expect_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        drain("divu_9_3");

        // Asynchronous reset in the middle of a run
        issue(1'b0, 32'd1000, 32'd10, e0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Extra start while busy must be ignored
        expect_op("divu_200_5", 1'b0, 32'd200, 32'd5, 32'd40, 32'd0, 1'b0, 33);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd7; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        drain("divu_200_5");
        repeat (40) @(negedge clk);
        chk("extra_start_idle", {31'd0, busy}, 32'd0);

`ifdef EX_DIV_EARLY_OUT_EN
        expect_op("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 2);
`else
        expect_op("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
`endif
        drain("divu_3_10");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
